// File: rtl/dram_sram_ld_if.sv
// dram_sram_ld_if: command, AXI4 read and SRAM write bundle for dram_sram_ld_engine.
// master = the engine, slave = the LSU/interconnect/SRAM side.
interface dram_sram_ld_if #(
   parameter int ID_W    = 8,
   parameter int DADDR_W = 31,
   parameter int EADDR_W = 8
);
   logic               cmd_vld;
   logic               cmd_rdy;
   logic [ID_W-1:0]    cmd_id;
   logic [DADDR_W-1:0] cmd_dram_addr;
   logic [7:0]         cmd_len;
   logic [3:0]         cmd_num;
   logic [2:0]         cmd_str;
   logic [11:0]        cmd_sram_addr;
   logic [ID_W-1:0]    axi_arid;
   logic [DADDR_W-1:0] axi_araddr;
   logic [7:0]         axi_arlen;
   logic [2:0]         axi_arsize;
   logic [1:0]         axi_arburst;
   logic               axi_arvalid;
   logic               axi_arready;
   logic [ID_W-1:0]    axi_rid;
   logic [31:0]        axi_rdata;
   logic [1:0]         axi_rresp;
   logic               axi_rlast;
   logic               axi_rvalid;
   logic               axi_rready;
   logic               sram_cen;
   logic               sram_wen;
   logic [EADDR_W-1:0] sram_addr;
   logic [127:0]       sram_din;
   logic [3:0]         sram_wmask;
   logic               ld_done;
   logic               ld_err;
   logic               ld_busy;

   modport master (
      input  cmd_vld, cmd_id, cmd_dram_addr, cmd_len, cmd_num, cmd_str, cmd_sram_addr,
      input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      output cmd_rdy, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
      output axi_rready, sram_cen, sram_wen, sram_addr, sram_din, sram_wmask,
      output ld_done, ld_err, ld_busy
   );

   modport slave (
      output cmd_vld, cmd_id, cmd_dram_addr, cmd_len, cmd_num, cmd_str, cmd_sram_addr,
      output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      input  cmd_rdy, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
      input  axi_rready, sram_cen, sram_wen, sram_addr, sram_din, sram_wmask,
      input  ld_done, ld_err, ld_busy
   );
endinterface

// File: rtl/dram_sram_ld_engine.sv
// dram_sram_ld_engine: AXI4 INCR read bursts packed into masked 128-bit SRAM entry writes.
// Define LD_ENGINE_RESP_CHK_EN to enable rresp/rid/beat-count error checking (ld_err).
module dram_sram_ld_engine #(
   parameter int ID_W    = 8,
   parameter int DADDR_W = 31,
   parameter int EADDR_W = 8
) (
   input logic            clk,
   input logic            rst_n,
   dram_sram_ld_if.master bus
);
   typedef enum logic [1:0] {IDLE, AR, DATA, DONE} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [DADDR_W-1:0] addr_q, addr_d;
   logic [7:0]         len_q, len_d, beat_q, beat_d;
   logic [3:0]         num_q, num_d, burst_q, burst_d;
   logic [2:0]         str_q, str_d;
   logic [EADDR_W-1:0] entry_q, entry_d, waddr_q, waddr_d;
   logic [1:0]         lane_q, lane_d;
   logic [3:0]         macc_q, macc_d, wmask_q, wmask_d;
   logic [127:0]       pack_q, pack_d;
   logic               rdy_q, rdy_d, arv_q, arv_d, rrdy_q, rrdy_d;
   logic               wr_q, wr_d, done_q, done_d, err_q, err_d;
   logic               beat, keep, wr;
   logic [3:0]         lmask;
   logic               unused_bits;

   assign unused_bits     = ^{bus.axi_rid, bus.axi_rresp, bus.cmd_sram_addr[1:0]};
   assign bus.cmd_rdy     = rdy_q;
   assign bus.axi_arid    = id_q;
   assign bus.axi_araddr  = addr_q;
   assign bus.axi_arlen   = len_q;
   assign bus.axi_arsize  = 3'b010;
   assign bus.axi_arburst = 2'b01;
   assign bus.axi_arvalid = arv_q;
   assign bus.axi_rready  = rrdy_q;
   assign bus.sram_cen    = wr_q;
   assign bus.sram_wen    = wr_q;
   assign bus.sram_addr   = waddr_q;
   assign bus.sram_din    = pack_q;
   assign bus.sram_wmask  = wmask_q;
   assign bus.ld_done     = done_q;
   assign bus.ld_err      = err_q;
   assign bus.ld_busy     = state_q != IDLE;

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      num_d   = num_q;
      str_d   = str_q;
      entry_d = entry_q;
      lane_d  = lane_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      macc_d  = macc_q;
      pack_d  = pack_q;
      waddr_d = waddr_q;
      err_d   = err_q;
      beat    = rrdy_q && bus.axi_rvalid;
`ifdef LD_ENGINE_RESP_CHK_EN
      keep    = beat && bus.axi_rid == id_q;
`else
      keep    = beat;
`endif
      wr      = keep && (lane_q == 2'd3 || bus.axi_rlast);
      lmask   = macc_q | (4'b1 << lane_q);
      case (state_q)
         IDLE: if (bus.cmd_vld && rdy_q) begin
            id_d    = bus.cmd_id;
            addr_d  = bus.cmd_dram_addr;
            len_d   = bus.cmd_len;
            num_d   = bus.cmd_num;
            str_d   = bus.cmd_str;
            entry_d = EADDR_W'(bus.cmd_sram_addr[11:4]);
            lane_d  = bus.cmd_sram_addr[3:2];
            burst_d = 4'd0;
            beat_d  = 8'd0;
            macc_d  = 4'd0;
            err_d   = 1'b0;
            state_d = AR;
         end
         AR: if (bus.axi_arready) state_d = DATA;
         DATA: if (beat && bus.axi_rlast) begin
            state_d = burst_q == num_q ? DONE : AR;
            burst_d = burst_q + 4'd1;
            addr_d  = addr_q + (DADDR_W'(16) << str_q);
         end
         default: state_d = IDLE;
      endcase
      // lanes keep filling across bursts; a flush only clears the accumulated mask
      if (keep) begin
         pack_d[32*lane_q +: 32] = bus.axi_rdata;
         lane_d  = lane_q + 2'd1;
         entry_d = lane_q == 2'd3 ? entry_q + EADDR_W'(1) : entry_q;
         macc_d  = wr ? 4'd0 : lmask;
         waddr_d = entry_q;
      end
      if (beat) beat_d = bus.axi_rlast ? 8'd0 : beat_q + 8'd1;
`ifdef LD_ENGINE_RESP_CHK_EN
      if (beat && (bus.axi_rresp != 2'b00 || bus.axi_rid != id_q || (bus.axi_rlast && beat_q != len_q)))
         err_d = 1'b1;
`endif
      wr_d    = wr;
      wmask_d = wr ? lmask : 4'd0;
      rdy_d   = state_d == IDLE;
      arv_d   = state_d == AR;
      rrdy_d  = state_d == DATA;
      done_d  = state_d == DONE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         num_q   <= '0;
         str_q   <= '0;
         entry_q <= '0;
         lane_q  <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         macc_q  <= '0;
         pack_q  <= '0;
         waddr_q <= '0;
         wmask_q <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         rdy_q   <= 1'b0;
         arv_q   <= 1'b0;
         rrdy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         num_q   <= num_d;
         str_q   <= str_d;
         entry_q <= entry_d;
         lane_q  <= lane_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         macc_q  <= macc_d;
         pack_q  <= pack_d;
         waddr_q <= waddr_d;
         wmask_q <= wmask_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         rdy_q   <= rdy_d;
         arv_q   <= arv_d;
         rrdy_q  <= rrdy_d;
         done_q  <= done_d;
      end
endmodule

// File: tb/tb_dram_sram_ld_engine.sv
// tb_dram_sram_ld_engine: table-driven load commands against a scripted AXI slave and an SRAM write monitor.
// Expected ld_err follows LD_ENGINE_RESP_CHK_EN.
module tb_dram_sram_ld_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dram_sram_ld_if bus ();
   dram_sram_ld_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef LD_ENGINE_RESP_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct packed {
      logic [30:0]     addr;
      logic [7:0]      len;
      logic [3:0]      num;
      logic [2:0]      str;
      logic [11:0]     sram;
      logic            stall;
      logic [7:0]      errb;
      logic [2:0]      nwr;
      logic [3:0][7:0] ent;
      logic [3:0][3:0] msk;
      logic [3:0][7:0] fb;
   } vec_t;

   vec_t         vecs [6];
   int           checks = 0;
   int           failures = 0;
   logic [7:0]   wq_a [$];
   logic [3:0]   wq_m [$];
   logic [127:0] wq_d [$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [30:0] a, input int g);
      return {a[15:0] ^ 16'hA5A5, 16'(g)};
   endfunction

   always @(negedge clk)
      if (bus.sram_cen) begin
         wq_a.push_back(bus.sram_addr);
         wq_m.push_back(bus.sram_wmask);
         wq_d.push_back(bus.sram_din);
         chk("wen", 128'(bus.sram_wen), 128'(1));
      end

   function automatic logic any_out();
      return |{bus.cmd_rdy, bus.axi_arvalid, bus.axi_araddr, bus.axi_arlen, bus.axi_arid, bus.axi_rready,
               bus.sram_cen, bus.sram_wen, bus.sram_addr, bus.sram_din, bus.sram_wmask,
               bus.ld_done, bus.ld_err, bus.ld_busy};
   endfunction

   task automatic run(input vec_t v, input int idx);
      int           n, gb, j;
      logic [7:0]   id;
      logic [30:0]  ea;
      logic [127:0] d;
      logic [3:0]   m;
      id = 8'h40 + 8'(idx);
      wq_a.delete(); wq_m.delete(); wq_d.delete();
      n = 0;
      while (!bus.cmd_rdy && n < 20) begin @(negedge clk); n++; end
      chk("cmd_rdy", 128'(bus.cmd_rdy), 128'(1));
      bus.cmd_vld = 1'b1; bus.cmd_id = id; bus.cmd_dram_addr = v.addr; bus.cmd_len = v.len;
      bus.cmd_num = v.num; bus.cmd_str = v.str; bus.cmd_sram_addr = v.sram;
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      chk("busy", 128'(bus.ld_busy), 128'(1));
      chk("err_clr", 128'(bus.ld_err), 128'(0));
      gb = 0;
      for (int b = 0; b <= int'(v.num); b++) begin
         n = 0;
         while (!bus.axi_arvalid && n < 20) begin @(negedge clk); n++; end
         chk("ar_gap", 128'(n), 128'(0));
         ea = v.addr + 31'(b * (16 << v.str));
         chk("araddr", 128'(bus.axi_araddr), 128'(ea));
         chk("arlen", 128'(bus.axi_arlen), 128'(v.len));
         chk("arid", 128'(bus.axi_arid), 128'(id));
         chk("arsize_burst", 128'({bus.axi_arsize, bus.axi_arburst}), 128'(5'b010_01));
         if (v.stall)
            for (int s = 0; s < 5; s++) begin
               bus.cmd_vld = 1'b1; bus.cmd_dram_addr = 31'h5555_0000;
               @(negedge clk);
               chk("ar_hold_v", 128'(bus.axi_arvalid), 128'(1));
               chk("ar_hold_a", 128'(bus.axi_araddr), 128'(ea));
               chk("rdy_while_busy", 128'(bus.cmd_rdy), 128'(0));
            end
         bus.cmd_vld = 1'b0;
         bus.axi_arready = 1'b1;
         @(negedge clk);
         bus.axi_arready = 1'b0;
         for (int k = 0; k <= int'(v.len); k++) begin
            if (v.stall) begin @(negedge clk); @(negedge clk); end
            chk("rready", 128'(bus.axi_rready), 128'(1));
            bus.axi_rvalid = 1'b1; bus.axi_rdata = pat(v.addr, gb); bus.axi_rid = id;
            bus.axi_rlast = k == int'(v.len);
            bus.axi_rresp = gb == int'(v.errb) ? 2'b10 : 2'b00;
            @(negedge clk);
            bus.axi_rvalid = 1'b0; bus.axi_rlast = 1'b0; bus.axi_rresp = 2'b00;
            gb++;
         end
      end
      chk("done", 128'(bus.ld_done), 128'(1));
      chk("done_wr", 128'(bus.sram_cen), 128'(1));
      chk("ld_err", 128'(bus.ld_err), 128'(CHK && v.errb != 8'hFF));
      @(negedge clk);
      chk("done_pulse", 128'(bus.ld_done), 128'(0));
      chk("rdy_back", 128'(bus.cmd_rdy), 128'(1));
      chk("idle", 128'(bus.ld_busy), 128'(0));
      chk("rready_idle", 128'(bus.axi_rready), 128'(0));
      chk("nwr", 128'(wq_a.size()), 128'(v.nwr));
      for (int w = 0; w < int'(v.nwr) && w < wq_a.size(); w++) begin
         chk("w_addr", 128'(wq_a[w]), 128'(v.ent[w]));
         chk("w_mask", 128'(wq_m[w]), 128'(v.msk[w]));
         d = wq_d[w];
         m = v.msk[w];
         j = 0;
         for (int l = 0; l < 4; l++)
            if (m[l]) begin
               chk("w_lane", 128'(d[32*l +: 32]), 128'(pat(v.addr, int'(v.fb[w]) + j)));
               j++;
            end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_vld = 1'b0; bus.cmd_id = '0; bus.cmd_dram_addr = '0; bus.cmd_len = '0;
      bus.cmd_num = '0; bus.cmd_str = '0; bus.cmd_sram_addr = '0; bus.axi_arready = 1'b0;
      bus.axi_rid = '0; bus.axi_rdata = '0; bus.axi_rresp = '0; bus.axi_rlast = 1'b0; bus.axi_rvalid = 1'b0;
      //            addr           len   num   str   sram     stl   errb   nwr   entries                          masks                        first beats
      vecs[0] = '{31'h100,      8'd3, 4'd0, 3'd0, 12'h050, 1'b0, 8'hFF, 3'd1, {8'h0, 8'h0, 8'h0, 8'h05},   {4'h0, 4'h0, 4'h0, 4'hF}, {8'd0, 8'd0, 8'd0, 8'd0}};
      vecs[1] = '{31'h200,      8'd3, 4'd0, 3'd0, 12'h058, 1'b0, 8'hFF, 3'd2, {8'h0, 8'h0, 8'h06, 8'h05},  {4'h0, 4'h0, 4'h3, 4'hC}, {8'd0, 8'd0, 8'd2, 8'd0}};
      vecs[2] = '{31'h1000,     8'd1, 4'd2, 3'd2, 12'h020, 1'b0, 8'hFF, 3'd3, {8'h0, 8'h03, 8'h02, 8'h02}, {4'h0, 4'h3, 4'hC, 4'h3}, {8'd0, 8'd4, 8'd2, 8'd0}};
      vecs[3] = '{31'h100,      8'd3, 4'd0, 3'd0, 12'h050, 1'b1, 8'hFF, 3'd1, {8'h0, 8'h0, 8'h0, 8'h05},   {4'h0, 4'h0, 4'h0, 4'hF}, {8'd0, 8'd0, 8'd0, 8'd0}};
      vecs[4] = '{31'h300,      8'd7, 4'd0, 3'd0, 12'hFF0, 1'b0, 8'd2,  3'd2, {8'h0, 8'h0, 8'h00, 8'hFF},  {4'h0, 4'h0, 4'hF, 4'hF}, {8'd0, 8'd0, 8'd4, 8'd0}};
      vecs[5] = '{31'h7FFFFFF0, 8'd0, 4'd1, 3'd0, 12'h0FC, 1'b0, 8'hFF, 3'd2, {8'h0, 8'h0, 8'h10, 8'h0F},  {4'h0, 4'h0, 4'h1, 4'h8}, {8'd0, 8'd0, 8'd1, 8'd0}};
      repeat (2) @(negedge clk);
      chk("reset_outs", 128'(any_out()), 128'(0));
      chk("reset_const", 128'({bus.axi_arsize, bus.axi_arburst}), 128'(5'b010_01));
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) run(vecs[i], i);
      // reset while two beats into a burst
      wq_a.delete(); wq_m.delete(); wq_d.delete();
      bus.cmd_vld = 1'b1; bus.cmd_id = 8'h77; bus.cmd_dram_addr = 31'h400; bus.cmd_len = 8'd3;
      bus.cmd_num = 4'd0; bus.cmd_str = 3'd0; bus.cmd_sram_addr = 12'h000;
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      chk("rst_ar", 128'(bus.axi_arvalid), 128'(1));
      bus.axi_arready = 1'b1;
      @(negedge clk);
      bus.axi_arready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.axi_rvalid = 1'b1; bus.axi_rid = 8'h77; bus.axi_rdata = 32'hBEEF_0000 + 32'(k);
         @(negedge clk);
      end
      bus.axi_rvalid = 1'b0;
      chk("rst_pre_busy", 128'(bus.ld_busy), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", 128'(any_out()), 128'(0));
      @(negedge clk);
      chk("rst_mid_nowr", 128'(wq_a.size()), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      run(vecs[1], 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
